ysyx_25010008_ifu: RTL

- Instruction fetch unit sitting directly upstream of the decode stage.
- Holds the architectural PC and fetches one 32-bit instruction from instruction memory over a valid/ready request and response handshake.
- Presents the fetched word to decode as inst plus a one-cycle valid pulse.
- Waits for the commit/next-PC report from downstream before fetching again (single instruction in flight, multi-cycle core).

---
 rtl/ysyx_25010008_ifu_if.sv | 30 +++
 rtl/ysyx_25010008_ifu.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ysyx_25010008_ifu_if.sv
// ysyx_25010008_ifu_if
// Instruction-memory bus between the fetch unit (master) and instruction
// memory (slave).
//   imem_req_valid / imem_req_ready / imem_addr : request channel
//   imem_resp_valid / imem_rdata / imem_resp_err : response channel
// Handshake: a request transfers on a posedge where imem_req_valid and
// imem_req_ready are both high; while valid is high and ready is low the
// master keeps imem_addr stable. The response channel has no ready: the
// memory presents imem_resp_valid for one cycle and the master must take it
// then (the master only listens while it is waiting for a response).
interface ysyx_25010008_ifu_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_resp_valid;
  logic [31:0]       imem_rdata;
  logic              imem_resp_err;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_resp_valid, imem_rdata, imem_resp_err
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_resp_valid, imem_rdata, imem_resp_err
  );
endinterface

// File: rtl/ysyx_25010008_ifu.sv
// ysyx_25010008_ifu
// Instruction fetch unit for a multi-cycle core: holds the architectural PC,
// fetches one instruction at a time over the imem bus, hands it to decode
// with a one-cycle valid pulse, then waits for the commit report (dnpc)
// before fetching the next one.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   imem            instruction-memory bus (master side)
//   halt            EBREAK seen by decode, sampled with dnpc_valid
//   dnpc, dnpc_valid next PC and commit pulse from downstream
//   pc, inst, valid instruction handed to decode (valid pulses once)
//   fetch_err       sticky bus error, fetching stopped
//   halted          sticky halt taken
//   inst_count      number of valid pulses issued (wraps)
//   state_dbg       current FSM state encoding
module ysyx_25010008_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_25010008_ifu_if.master     imem,
  input  logic                    halt,
  input  logic [ADDR_W-1:0]       dnpc,
  input  logic                    dnpc_valid,
  output logic [ADDR_W-1:0]       pc,
  output logic [31:0]             inst,
  output logic                    valid,
  output logic                    fetch_err,
  output logic                    halted,
  output logic [31:0]             inst_count,
  output logic [2:0]              state_dbg
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    REQ         = 3'd0,
    WAIT_RESP   = 3'd1,
    ISSUE       = 3'd2,
    WAIT_COMMIT = 3'd3,
    STOP        = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [31:0]       inst_d;
  logic              fetch_err_d;
  logic              halted_d;
  logic [31:0]       inst_count_d;
  logic              req_valid_c;
  logic              valid_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      pc         <= ADDR_W'(RESET_PC);
      inst       <= NOP;
      fetch_err  <= 1'b0;
      halted     <= 1'b0;
      inst_count <= 32'd0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      inst       <= inst_d;
      fetch_err  <= fetch_err_d;
      halted     <= halted_d;
      inst_count <= inst_count_d;
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    inst_d       = inst;
    fetch_err_d  = fetch_err;
    halted_d     = halted;
    inst_count_d = inst_count;
    req_valid_c  = 1'b0;
    valid_c      = 1'b0;
    case (state)
      REQ: begin
        req_valid_c = 1'b1;
        if (imem.imem_req_ready) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        // Responses are only listened to here, so one arriving together
        // with request acceptance, or left over from before a reset, is dropped.
        if (imem.imem_resp_valid) begin
          if (imem.imem_resp_err) begin
            fetch_err_d = 1'b1;
            state_d     = STOP;
          end else begin
            inst_d  = imem.imem_rdata;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        valid_c      = 1'b1;
        inst_count_d = inst_count + 32'd1;
        state_d      = WAIT_COMMIT;
      end
      WAIT_COMMIT: begin
        if (dnpc_valid) begin
          if (halt || halted) begin
            halted_d = 1'b1;
            state_d  = STOP;
          end else begin
            // Low two bits are cleared rather than trapped on.
            pc_d    = dnpc & ~ADDR_W'(3);
            state_d = REQ;
          end
        end
      end
      STOP: begin
        state_d = STOP;
      end
      default: begin
        state_d = STOP;
      end
    endcase
  end

  assign imem.imem_req_valid = req_valid_c;
  assign imem.imem_addr      = pc;
  assign valid               = valid_c;
  assign state_dbg           = state;

endmodule
